// File: rtl/cs_adc_frame_packer.sv
// cs_adc_frame_packer
// Pairs left/right samples from the CS5343 ADC stream into stereo frames,
// re-synchronising on channel-order errors, and buffers frames in a small FIFO.
module cs_adc_frame_packer #(
    parameter int SAMPLE_WIDTH_P = 24,
    parameter int FIFO_DEPTH_P   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [SAMPLE_WIDTH_P-1:0]         adc_data,
    input  logic                              adc_valid,
    output logic                              adc_ready,
    input  logic                              adc_last,
    output logic [SAMPLE_WIDTH_P-1:0]         frame_left,
    output logic [SAMPLE_WIDTH_P-1:0]         frame_right,
    output logic                              frame_valid,
    input  logic                              frame_ready,
    output logic [$clog2(FIFO_DEPTH_P):0]     frame_fill,
    input  logic                              clr_errors,
    output logic [15:0]                       sync_error_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH_P);
    localparam int FILL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;
    logic                      w_adcReady;
    logic                      w_accept;
    logic                      w_loadLeft;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_syncErr;
    logic                      w_full;

    logic [SAMPLE_WIDTH_P-1:0] r_left;
    logic [SAMPLE_WIDTH_P-1:0] r_memLeft  [FIFO_DEPTH_P];
    logic [SAMPLE_WIDTH_P-1:0] r_memRight [FIFO_DEPTH_P];
    logic [PTR_W-1:0]          r_wrPtr;
    logic [PTR_W-1:0]          r_rdPtr;
    logic [FILL_W-1:0]         r_fill;
    logic [15:0]               r_errCnt;

    assign w_full = (r_fill == FILL_W'(FIFO_DEPTH_P));
    assign w_pop  = (r_fill != '0) && frame_ready;

    // Channel-order state register; reset lands in SYNC so a new stream starts on a right beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, input handshake, and per-beat decisions (load left, push frame, flag error).
    always_comb begin
        w_nextState = r_state;
        w_adcReady  = 1'b1;
        w_accept    = 1'b0;
        w_loadLeft  = 1'b0;
        w_push      = 1'b0;
        w_syncErr   = 1'b0;
        if (r_state == ST_RIGHT) begin
            w_adcReady = !w_full;
        end
        w_accept = adc_valid && w_adcReady;
        case (r_state)
            ST_SYNC: begin
                if (w_accept && adc_last) begin
                    w_nextState = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (w_accept) begin
                    if (!adc_last) begin
                        w_loadLeft  = 1'b1;
                        w_nextState = ST_RIGHT;
                    end else begin
                        w_syncErr = 1'b1;
                    end
                end
            end
            ST_RIGHT: begin
                if (w_accept) begin
                    if (adc_last) begin
                        w_push      = 1'b1;
                        w_nextState = ST_LEFT;
                    end else begin
                        w_syncErr  = 1'b1;
                        w_loadLeft = 1'b1;
                    end
                end
            end
            default: begin
                w_nextState = ST_SYNC;
            end
        endcase
    end

    // Holds the pending left sample until its right partner arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left <= '0;
        end else if (w_loadLeft) begin
            r_left <= adc_data;
        end
    end

    // Frame storage; cleared on reset so the head outputs read zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH_P; i++) begin
                r_memLeft[i]  <= '0;
                r_memRight[i] <= '0;
            end
        end else if (w_push) begin
            r_memLeft[r_wrPtr]  <= r_left;
            r_memRight[r_wrPtr] <= adc_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two; fill tracks push/pop together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_fill  <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Saturating channel-order error counter; a clear request beats a same-cycle error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCnt <= '0;
        end else if (clr_errors) begin
            r_errCnt <= '0;
        end else if (w_syncErr && (r_errCnt != 16'hFFFF)) begin
            r_errCnt <= r_errCnt + 16'd1;
        end
    end

    assign adc_ready      = w_adcReady;
    assign frame_left     = r_memLeft[r_rdPtr];
    assign frame_right    = r_memRight[r_rdPtr];
    assign frame_valid    = (r_fill != '0);
    assign frame_fill     = r_fill;
    assign sync_error_cnt = r_errCnt;

endmodule

// File: doc/cs_adc_frame_packer.md
CS_ADC_FRAME_PACKER -- requirements
Module: cs_adc_frame_packer

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH_P, default 24, bits per audio sample.
REQ-002 SHALL have parameter FIFO_DEPTH_P, default 4, frame FIFO depth; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port adc_data  input  SAMPLE_WIDTH_P  sample from the CS5343 AXI-S ADC stream.
REQ-006 SHALL have port adc_valid  input  1  sample valid.
REQ-007 SHALL have port adc_ready  output  1  sample accepted when high with adc_valid.
REQ-008 SHALL have port adc_last  input  1  high on the right-channel sample; low on the left-channel sample.
REQ-009 SHALL have port frame_left  output  SAMPLE_WIDTH_P  left sample of the head frame.
REQ-010 SHALL have port frame_right  output  SAMPLE_WIDTH_P  right sample of the head frame.
REQ-011 SHALL have port frame_valid  output  1  head frame valid.
REQ-012 SHALL have port frame_ready  input  1  consumer accepts head frame.
REQ-013 SHALL have port frame_fill  output  $clog2(FIFO_DEPTH_P)+1  frames held.
REQ-014 SHALL have port clr_errors  input  1  synchronous clear of sync_error_cnt.
REQ-015 SHALL have port sync_error_cnt  output  16  saturating count of channel-order violations.

Function
REQ-016 Handshakes: a beat transfers on a rising clk edge where valid and ready are both high; frame_valid and frame_left/right SHALL hold stable until frame_ready.
REQ-017 FSM states: SYNC, LEFT, RIGHT; reset state SYNC.
REQ-018 SYNC: adc_ready=1; accepted beat with adc_last=1 -> LEFT; adc_last=0 -> discard, stay SYNC; no error counted.
REQ-019 LEFT: adc_ready=1; accepted beat with adc_last=0 -> register as left sample, go RIGHT; adc_last=1 -> discard, sync error +1, stay LEFT.
REQ-020 RIGHT: adc_ready = NOT FIFO full; accepted beat with adc_last=1 -> push {left, right} frame, go LEFT.
REQ-021 RIGHT, accepted beat with adc_last=0: sync error +1, replace held left sample with this beat, stay RIGHT; no push.
REQ-022 Full FIFO SHALL stall only in RIGHT; no frame SHALL ever be dropped or overwritten; a same-cycle pop does not enable a push when full.
REQ-023 Latency: right beat accepted at edge N into an empty FIFO -> frame_valid=1 after edge N.
REQ-024 Simultaneous push and pop: fill unchanged, both take effect.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH_P; full at fill=FIFO_DEPTH_P, empty at fill=0.
REQ-026 frame_valid = (fill != 0); frame_fill updates on the same edge as push/pop.
REQ-027 sync_error_cnt saturates at 0xFFFF; clr_errors high -> counter 0 on next edge, clear wins over a same-cycle error.
REQ-028 Samples SHALL pass bit-exact; no sign extension or arithmetic.

Reset
REQ-029 While rst_n low: state SYNC, adc_ready=1, frame_valid=0, frame_fill=0, frame_left=0, frame_right=0, sync_error_cnt=0, pointers 0.
REQ-030 Reset asserted mid-frame SHALL discard the held left sample and all buffered frames; after release the block re-synchronises via SYNC.
REQ-031 Deassertion SHALL take effect on the next clk edge; no output glitches on assertion beyond immediate reset values.

Verification
REQ-032 After reset, beats (L=0x000001,last=0),(R=0x000002,last=1),(0x111111,0),(0x222222,1), frame_ready=1 -> first pair discarded in SYNC, one frame {0x111111,0x222222}, sync_error_cnt=0.
REQ-033 In LEFT, two consecutive last=1 beats -> sync_error_cnt=2, no frames pushed; next 0xAAAAAA/0xBBBBBB pair emits {0xAAAAAA,0xBBBBBB}.
REQ-034 In RIGHT, left 0x000010 then left 0x000020 then right 0x000030 -> one frame {0x000020,0x000030}, sync_error_cnt=1.
REQ-035 frame_ready=0, push 5 frames with depth 4 -> frame_fill=4, adc_ready=0 in RIGHT on 5th right beat; raise frame_ready -> all 5 frames out in order, none lost.
REQ-036 Force 65537 errors, then clr_errors concurrent with an error -> count reads 0xFFFF before, 0 after.
REQ-037 Assert rst_n low while 2 frames buffered and in RIGHT -> frame_valid=0, frame_fill=0 immediately; after release, first beat with last=0 is discarded.
